gate_sweep_checker: RTL
=======================

# gate_sweep_checker

Synthesizable exhaustive truth-table checker for N-input combinational gates: drives every input vector onto a device under test, waits a programmable settle time, compares the DUT result against a built-in golden model, and reports pass/fail. It is the parametrised, self-checking successor to the hand-written directed gate benches in the lecture labs. It sits beside any gate under test, in simulation or on the board.

## Interface
- N_IN, default 2: number of DUT inputs; legal range 1..8; sweep length is 2^N_IN vectors.
- SETTLE, default 5: clock cycles each vector is held before sampling; legal range at least 1.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  begin a sweep; sampled only in IDLE.
- op  input  2  golden function: 0 AND, 1 OR, 2 XOR, 3 NAND; latched at start.
- stim  output  N_IN  registered stimulus to DUT inputs.
- dut_result  input  1  DUT output.
- busy  output  1  high while the sweep runs (SETTLE or CHECK state).
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  high when err_count == 0 after a completed sweep; held until next start or reset.
- err_count  output  N_IN+1  number of mismatching vectors in the last sweep.
- fail_valid  output  1  at least one mismatch recorded this sweep.
- first_fail_vec  output  N_IN  stim value of the first mismatch; valid when fail_valid is high.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Reset enters IDLE.
- Reset values: stim 0, busy 0, done 0, pass 0, err_count 0, fail_valid 0, first_fail_vec 0, settle counter 0.
- IDLE with start=1: latch op; clear stim, err_count, fail_valid, first_fail_vec, and pass; load the settle counter with SETTLE-1; go to SETTLE.
- SETTLE: decrement the counter. When the counter is 0, go to CHECK.
- CHECK: compute golden(op_latched, stim) with AND = &stim, OR = |stim, XOR = ^stim, NAND = ~&stim.
  - On a mismatch with dut_result: increment err_count. If fail_valid is 0, set fail_valid and capture stim into first_fail_vec.
  - If stim is all ones, go to DONE. Otherwise increment stim, reload the counter with SETTLE-1, and go to SETTLE.
- DONE: done=1 for one cycle; pass = (err_count == 0); go to IDLE.
- start is ignored outside IDLE. op changes after the latch are ignored.
- err_count width N_IN+1 holds the maximum of 2^N_IN, so no saturation is needed. stim never wraps, because the sweep ends at all ones.
- dut_result is used only in CHECK. It is not synchronised; the DUT is assumed driven combinationally from stim in the same clock domain.

## Timing
- stim updates on the edge that leaves IDLE and on each CHECK edge that continues the sweep.
- Each vector occupies exactly SETTLE+1 cycles: SETTLE cycles in SETTLE state, then 1 in CHECK.
- Start is sampled on edge E. The last CHECK occurs at edge E + 2^N_IN*(SETTLE+1), and done is high in the following cycle.
- busy rises on the edge after start is sampled and falls on the edge entering DONE.
- Asserting rst mid-sweep immediately forces all reset values, including stim=0 and pass=0. The sweep is abandoned, and no done pulse is produced.

## Configuration
- GATE_SWEEP_STOP_ON_FAIL_EN defined: a mismatch in CHECK ends the sweep by going straight to DONE. err_count is then 1 and pass is 0, and stim holds the failing vector.
- GATE_SWEEP_STOP_ON_FAIL_EN undefined: the sweep always covers all 2^N_IN vectors, and err_count reports the total mismatch count.

## Test plan
- N_IN=2, SETTLE=5, op=0, correct AND DUT, start pulse -> stim steps 00, 01, 10, 11 every 6 cycles; done 24 cycles after start; pass=1; err_count=0; fail_valid=0.
- N_IN=2, op=1 (OR), DUT stuck at 0, macro undefined -> err_count=3, first_fail_vec=2'b01, fail_valid=1, pass=0.
- Same stimulus as the previous case, macro defined -> done after vector 01 (12 cycles after start), err_count=1, first_fail_vec=2'b01, stim=2'b01.
- N_IN=4, SETTLE=1, op=2, correct XOR DUT -> 16 vectors, done 32 cycles after start, pass=1. Toggling op and start mid-sweep has no effect.
- rst asserted asynchronously during vector 10, then a new start with op=3 and a correct NAND DUT -> outputs go to reset values immediately with no done pulse; the fresh sweep passes with err_count=0.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table checker: walks stim through every N_IN-bit vector and compares dut_result to a golden gate.
// Optional macro GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  output logic [N_IN-1:0] stim,
  input  logic            dut_result,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] STIM_ONE = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t        state, state_nx;
  logic [1:0]    op_q;
  logic [CW-1:0] cnt;
  logic          golden, mismatch, end_sweep;

  always_comb begin
    golden = 1'b0;
    unique case (op_q)
      2'd0: golden = &stim;
      2'd1: golden = |stim;
      2'd2: golden = ^stim;
      2'd3: golden = ~&stim;
    endcase
  end

  assign mismatch  = golden ^ dut_result;
  // The sweep never wraps: all-ones is the final vector.
  assign end_sweep = (&stim) || (STOP_ON_FAIL && mismatch);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_nx = S_CHECK;
      S_CHECK:  state_nx = end_sweep ? S_DONE : S_SETTLE;
      S_DONE:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q           <= '0;
      cnt            <= '0;
      stim           <= '0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          op_q           <= op;
          cnt            <= CNT_LOAD;
          stim           <= '0;
          pass           <= 1'b0;
          err_count      <= '0;
          fail_valid     <= 1'b0;
          first_fail_vec <= '0;
        end
        S_SETTLE: if (cnt != '0) cnt <= cnt - CNT_ONE;
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_vec <= stim;
            end
          end
          // pass is resolved on entry to DONE so it is already valid alongside the done pulse.
          if (end_sweep) pass <= (err_count == '0) && !mismatch;
          else begin
            stim <= stim + STIM_ONE;
            cnt  <= CNT_LOAD;
          end
        end
        S_DONE: ;
      endcase
    end
  end

  assign busy = (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);

endmodule
